// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 integer divider for MIPS DIV/DIVU in the EX stage.
// Quotient goes to LO, remainder to HI; the pipeline is stalled while the divide runs.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_a,
  input  logic [WIDTH-1:0] div_b,
  input  logic             div_cancel,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quot,
  output logic [WIDTH-1:0] div_rem,
  output logic             stall_div
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic [1:0]       state_r, state_nx_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] dvd_r, dvs_r, rem_r, a_orig_r;
  logic [WIDTH-1:0] quot_prev_r, rem_prev_r;
  logic             q_neg_r, r_neg_r, dz_r, done_r;

  logic             start_ok_s, last_s, q_bit_s;
  logic [WIDTH:0]   part_s, diff_s;
  logic [WIDTH-1:0] rem_next_s, quot_next_s, fin_quot_s, fin_rem_s;

  assign start_ok_s = (state_r == IDLE) && div_start && !div_cancel;
  assign last_s     = (state_r == CALC) && (cnt_r == CNT_LAST);
  assign stall_div  = start_ok_s || (state_r == CALC);
  assign div_busy   = (state_r == CALC);
  assign div_done   = done_r && !div_cancel;

  // One restoring step; the extra partial bit keeps divisors above 2^(WIDTH-1) exact.
  always_comb begin
    part_s      = {rem_r, dvd_r[WIDTH-1]};
    diff_s      = part_s - {1'b0, dvs_r};
    q_bit_s     = ~diff_s[WIDTH];
    rem_next_s  = q_bit_s ? diff_s[WIDTH-1:0] : part_s[WIDTH-1:0];
    quot_next_s = {dvd_r[WIDTH-2:0], q_bit_s};
  end

  // Sign correction and the fixed divide-by-zero result.
  always_comb begin
    if (dz_r) begin
      fin_quot_s = {WIDTH{1'b1}};
      fin_rem_s  = a_orig_r;
    end else begin
      fin_quot_s = negate_if(quot_next_s, q_neg_r);
      fin_rem_s  = negate_if(rem_next_s, r_neg_r);
    end
  end

  // Next-state logic; cancel always returns to IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = start_ok_s ? CALC : IDLE;
      CALC: begin
        if (div_cancel)  state_nx_s = IDLE;
        else if (last_s) state_nx_s = DONE;
        else             state_nx_s = CALC;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      dvd_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      a_orig_r    <= {WIDTH{1'b0}};
      quot_prev_r <= {WIDTH{1'b0}};
      rem_prev_r  <= {WIDTH{1'b0}};
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      dz_r        <= 1'b0;
      done_r      <= 1'b0;
      div_quot    <= {WIDTH{1'b0}};
      div_rem     <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nx_s;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            dvd_r    <= magnitude(div_a, div_signed);
            dvs_r    <= magnitude(div_b, div_signed);
            rem_r    <= {WIDTH{1'b0}};
            a_orig_r <= div_a;
            q_neg_r  <= div_signed && (div_a[WIDTH-1] ^ div_b[WIDTH-1]);
            r_neg_r  <= div_signed && div_a[WIDTH-1];
            dz_r     <= (div_b == {WIDTH{1'b0}});
            cnt_r    <= {CW{1'b0}};
          end
        end
        CALC: begin
          if (!div_cancel) begin
            dvd_r <= quot_next_s;
            rem_r <= rem_next_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (last_s) begin
              quot_prev_r <= div_quot;
              rem_prev_r  <= div_rem;
              div_quot    <= fin_quot_s;
              div_rem     <= fin_rem_s;
              done_r      <= 1'b1;
            end
          end
        end
        DONE: begin
          // A flush during DONE withdraws the result just presented.
          if (div_cancel) begin
            div_quot <= quot_prev_r;
            div_rem  <= rem_prev_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide by zero, overflow, cancel, ignored restart and reset mid-operation.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, div_start, div_signed, div_cancel;
  logic [31:0] div_a, div_b;
  logic        div_busy, div_done, stall_div;
  logic [31:0] div_quot, div_rem;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .div_start(div_start), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b), .div_cancel(div_cancel),
    .div_busy(div_busy), .div_done(div_done), .div_quot(div_quot),
    .div_rem(div_rem), .stall_div(stall_div)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start a divide and follow it to DONE; optionally re-pulse start mid-CALC.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input bit restart);
    int n;
    @(negedge clk);
    div_signed = sgn; div_a = a; div_b = b; div_start = 1'b1;
    #1;
    n = 0;
    while (stall_div === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      div_start = (restart && n == 5);
      div_a = $urandom; div_b = $urandom; div_signed = $urandom_range(0, 1);
      #1;
    end
    div_start = 1'b0;
    check({tag, ".lat"}, 32'(n), 32'd33);
    check({tag, ".done"}, {31'd0, div_done}, 32'd1);
    check({tag, ".busy"}, {31'd0, div_busy}, 32'd0);
    check({tag, ".quot"}, div_quot, eq);
    check({tag, ".rem"}, div_rem, er);
    @(negedge clk); #1;
    check({tag, ".done_off"}, {31'd0, div_done}, 32'd0);
    check({tag, ".quot_hold"}, div_quot, eq);
    check({tag, ".rem_hold"}, div_rem, er);
  endtask

  initial begin
    int dones;
    rst = 1'b1; div_start = 1'b0; div_signed = 1'b0; div_cancel = 1'b0;
    div_a = 32'd0; div_b = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.busy", {31'd0, div_busy}, 32'd0);
    check("rst.done", {31'd0, div_done}, 32'd0);
    check("rst.quot", div_quot, 32'd0);
    check("rst.rem", div_rem, 32'd0);
    rst = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_div("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0);
    run_div("divu_dz", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0);
    run_div("div_dz", 1'b1, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b0);
    run_div("restart", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);

    // Cancel at iteration 10: no done, previous results kept.
    @(negedge clk);
    div_signed = 1'b0; div_a = 32'd1000; div_b = 32'd3; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    repeat (9) @(negedge clk);
    div_cancel = 1'b1;
    @(negedge clk);
    div_cancel = 1'b0;
    #1;
    check("cancel.busy", {31'd0, div_busy}, 32'd0);
    check("cancel.stall", {31'd0, stall_div}, 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (div_done === 1'b1) dones++;
    end
    check("cancel.no_done", 32'(dones), 32'd0);
    check("cancel.quot", div_quot, 32'd14);
    check("cancel.rem", div_rem, 32'd2);

    // Start and cancel together in IDLE: nothing starts.
    @(negedge clk);
    div_a = 32'd9; div_b = 32'd2; div_start = 1'b1; div_cancel = 1'b1;
    #1;
    check("startcancel.stall", {31'd0, stall_div}, 32'd0);
    @(negedge clk);
    div_start = 1'b0; div_cancel = 1'b0;
    #1;
    check("startcancel.busy", {31'd0, div_busy}, 32'd0);

    // Reset in the middle of CALC.
    @(negedge clk);
    div_a = 32'd500; div_b = 32'd7; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.busy", {31'd0, div_busy}, 32'd0);
    check("midrst.done", {31'd0, div_done}, 32'd0);
    check("midrst.stall", {31'd0, stall_div}, 32'd0);
    check("midrst.quot", div_quot, 32'd0);
    check("midrst.rem", div_rem, 32'd0);
    run_div("after_rst", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
